// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_sequencer_if
// Description : Request handshake and bus-cycle FSM signals of the RTC
//               transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if;
    logic       req;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;
    logic       timeout_err;
    logic       do_it;
    logic       w_r;
    logic       send_add;
    logic       send_data;
    logic       read_data;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    // Requester plus bus-cycle FSM side
    modport master (
        output req, req_wr, req_addr, req_wdata,
        input  ack, rdata, busy, timeout_err,
        input  do_it, w_r,
        output send_add, send_data, read_data,
        input  ad_out, ad_oe,
        output ad_in
    );

    // Sequencer side
    modport slave (
        input  req, req_wr, req_addr, req_wdata,
        output ack, rdata, busy, timeout_err,
        output do_it, w_r,
        input  send_add, send_data, read_data,
        output ad_out, ad_oe,
        input  ad_in
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_sequencer
// Description : Single-register read/write front-end for the RTC parallel bus;
//               starts one bus cycle, drives address/data, captures read data.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
    parameter int TIMEOUT_CYC = 48
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rtc_bus_sequencer_if.slave    bus
);

    localparam logic [5:0] c_last_cnt = 6'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ADD  = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_wr;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [5:0]  r_cnt;
    logic        r_add_q;
    logic        r_data_q;
    logic        r_rd_q;
    logic        r_captured;

    logic        w_add_fall;
    logic        w_final_fall;
    logic        w_rd_rise;
    logic        w_expired;
    logic        w_busy;
    logic        w_do_it;
    logic        w_ack;
    logic        w_timeout;
    logic        w_oe;
    logic [7:0]  w_ad_out;

    // Phase-flag history only records flags that belong to the current state,
    // so a stray flag can never fake an edge after a state change.
    assign w_add_fall   = r_add_q & ~bus.send_add;
    assign w_final_fall = r_wr ? (r_data_q & ~bus.send_data)
                               : (r_rd_q & ~bus.read_data);
    assign w_rd_rise    = (r_state == S_WAIT_DATA) & ~r_wr & bus.read_data
                          & ~r_rd_q & ~r_captured;
    assign w_expired    = (r_cnt == c_last_cnt);

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b1;
        w_do_it   = 1'b0;
        w_ack     = 1'b0;
        w_timeout = 1'b0;
        w_oe      = 1'b0;
        w_ad_out  = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.req) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_do_it = 1'b1;
                w_next  = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                w_ad_out = r_addr;
                w_oe     = bus.send_add;
                if (w_add_fall) begin
                    w_next = S_WAIT_DATA;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                // Reads keep the bus released: the RTC owns it in this phase.
                if (r_wr) begin
                    w_ad_out = r_wdata;
                    w_oe     = bus.send_data;
                end
                if (w_final_fall) begin
                    w_next = S_DONE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DONE: begin
                w_ack  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
            r_cnt      <= 6'd0;
            r_add_q    <= 1'b0;
            r_data_q   <= 1'b0;
            r_rd_q     <= 1'b0;
            r_captured <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.req) begin
                r_wr    <= bus.req_wr;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end

            r_add_q  <= (r_state == S_WAIT_ADD) & bus.send_add;
            r_data_q <= (r_state == S_WAIT_DATA) & r_wr & bus.send_data;
            r_rd_q   <= (r_state == S_WAIT_DATA) & ~r_wr & bus.read_data;

            // Counter equals the cycle index relative to the do_it cycle.
            if (r_state == S_IDLE) begin
                r_cnt <= 6'd0;
            end else if ((r_state == S_START) || (r_state == S_WAIT_ADD) ||
                         (r_state == S_WAIT_DATA)) begin
                r_cnt <= r_cnt + 6'd1;
            end

            if (r_state == S_START) begin
                r_captured <= 1'b0;
            end else if (w_rd_rise) begin
                r_captured <= 1'b1;
                r_rdata    <= bus.ad_in;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.do_it       = w_do_it;
    assign bus.ack         = w_ack;
    assign bus.timeout_err = w_timeout;
    assign bus.w_r         = (r_state != S_IDLE) & r_wr;
    assign bus.ad_oe       = w_oe;
    assign bus.ad_out      = w_ad_out;
    assign bus.rdata       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_sequencer
// Description : Directed self-checking bench driving the reference bus-cycle
//               profile against rtc_bus_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;

    localparam int c_mode_norm  = 0;
    localparam int c_mode_to    = 1;
    localparam int c_mode_stray = 2;
    localparam int c_mode_busy  = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_rdata = 8'h00;

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus ();

    rtc_bus_sequencer #(.TIMEOUT_CYC(48)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference bus-cycle profile, k counted from the do_it cycle.
    task automatic drive_bus(input int k, input bit wr, input int mode, input logic [7:0] rdv);
        bus.send_add  = (k >= 3 && k <= 12);
        bus.send_data = wr && (mode != c_mode_to) && (k >= 24 && k <= 34);
        bus.read_data = !wr && (k >= 32 && k <= 34);
        bus.ad_in     = (!wr && k == 32) ? rdv : 8'h00;
        if (mode == c_mode_stray) begin
            if (k == 1 || k == 2) bus.send_data = 1'b1;
            if (k == 15 || k == 16) begin
                bus.read_data = 1'b1;
                bus.ad_in     = 8'hFF;
            end
        end
    endtask

    task automatic bus_idle();
        bus.send_add  = 1'b0;
        bus.send_data = 1'b0;
        bus.read_data = 1'b0;
        bus.ad_in     = 8'h00;
    endtask

    task automatic issue_req(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        bus.req       = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
    endtask

    // Entered in the do_it cycle; returns one cycle after the first IDLE cycle.
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdv, input int mode);
        int  last;
        bit  exp_oe;
        last = (mode == c_mode_to) ? 47 : 36;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) bus.req = 1'b0;
            if (mode == c_mode_busy) begin
                if (k == 5) begin
                    bus.req = 1'b1; bus.req_wr = 1'b0;
                    bus.req_addr = 8'h99; bus.req_wdata = 8'hEE;
                end
                if (k == 11) bus.req = 1'b0;
                if (k == 30) begin
                    bus.req = 1'b1; bus.req_wr = 1'b0;
                    bus.req_addr = 8'h30; bus.req_wdata = 8'h00;
                end
            end
            drive_bus(k, wr, mode, rdv);
            #2;
            exp_oe = (k >= 3 && k <= 12) || (wr && mode != c_mode_to && k >= 24 && k <= 34);
            chk($sformatf("busy k=%0d", k), {7'd0, bus.busy}, 8'd1);
            chk($sformatf("w_r k=%0d", k), {7'd0, bus.w_r}, {7'd0, wr});
            chk($sformatf("do_it k=%0d", k), {7'd0, bus.do_it}, {7'd0, k == 0});
            chk($sformatf("ack k=%0d", k), {7'd0, bus.ack}, {7'd0, mode != c_mode_to && k == 36});
            chk($sformatf("timeout_err k=%0d", k), {7'd0, bus.timeout_err},
                {7'd0, mode == c_mode_to && k == 47});
            chk($sformatf("ad_oe k=%0d", k), {7'd0, bus.ad_oe}, {7'd0, exp_oe});
            if (exp_oe) chk($sformatf("ad_out k=%0d", k), bus.ad_out, (k <= 12) ? addr : wdata);
            if (k == last) begin
                if (!wr && mode != c_mode_to) exp_rdata = rdv;
                chk($sformatf("rdata k=%0d", k), bus.rdata, exp_rdata);
            end
            @(posedge clk); #1;
        end
        bus_idle();
        #2;
        chk("idle busy", {7'd0, bus.busy}, 8'd0);
        chk("idle ack", {7'd0, bus.ack}, 8'd0);
        chk("idle timeout_err", {7'd0, bus.timeout_err}, 8'd0);
        chk("idle do_it", {7'd0, bus.do_it}, 8'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.req = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", {7'd0, bus.busy}, 8'd0);
        chk("rst ack", {7'd0, bus.ack}, 8'd0);
        chk("rst timeout_err", {7'd0, bus.timeout_err}, 8'd0);
        chk("rst do_it", {7'd0, bus.do_it}, 8'd0);
        chk("rst w_r", {7'd0, bus.w_r}, 8'd0);
        chk("rst ad_oe", {7'd0, bus.ad_oe}, 8'd0);
        chk("rst ad_out", bus.ad_out, 8'h00);
        chk("rst rdata", bus.rdata, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        issue_req(1'b1, 8'h21, 8'h5A);
        run_txn(1'b1, 8'h21, 8'h5A, 8'h00, c_mode_norm);

        issue_req(1'b0, 8'h23, 8'h00);
        run_txn(1'b0, 8'h23, 8'h00, 8'h47, c_mode_norm);

        issue_req(1'b1, 8'h10, 8'hC3);
        run_txn(1'b1, 8'h10, 8'hC3, 8'h00, c_mode_to);

        issue_req(1'b0, 8'h24, 8'h00);
        run_txn(1'b0, 8'h24, 8'h00, 8'h33, c_mode_norm);

        // Busy rejection, then the request held through DONE starts a read.
        issue_req(1'b1, 8'h40, 8'h11);
        run_txn(1'b1, 8'h40, 8'h11, 8'h00, c_mode_busy);
        run_txn(1'b0, 8'h30, 8'h00, 8'h6C, c_mode_norm);

        issue_req(1'b1, 8'h50, 8'h22);
        run_txn(1'b1, 8'h50, 8'h22, 8'h00, c_mode_stray);

        // Reset in cycle 28 of a write while send_data is high.
        issue_req(1'b1, 8'h60, 8'h77);
        bus.req = 1'b0;
        for (int k = 0; k < 28; k++) begin
            drive_bus(k, 1'b1, c_mode_norm, 8'h00);
            @(posedge clk); #1;
        end
        drive_bus(28, 1'b1, c_mode_norm, 8'h00);
        #1;
        chk("pre-reset ad_oe", {7'd0, bus.ad_oe}, 8'd1);
        reset = 1'b0;
        #1;
        chk("mid-reset ad_oe", {7'd0, bus.ad_oe}, 8'd0);
        chk("mid-reset do_it", {7'd0, bus.do_it}, 8'd0);
        chk("mid-reset busy", {7'd0, bus.busy}, 8'd0);
        chk("mid-reset w_r", {7'd0, bus.w_r}, 8'd0);
        bus_idle();
        exp_rdata = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #3;
            chk($sformatf("post-reset ack c=%0d", k), {7'd0, bus.ack}, 8'd0);
            chk($sformatf("post-reset timeout_err c=%0d", k), {7'd0, bus.timeout_err}, 8'd0);
            chk($sformatf("post-reset busy c=%0d", k), {7'd0, bus.busy}, 8'd0);
        end
        chk("post-reset rdata", bus.rdata, exp_rdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Transaction front-end for the RTC parallel-bus controller. Accepts single register read/write requests over a req/ack handshake and starts one bus cycle on the downstream bus-cycle FSM with a `do_it` pulse and a held `w_r`. Drives the multiplexed address/data bus during that FSM's `send_add`/`send_data` phases and captures read data during `read_data`. Reports completion with `ack`, or abandonment with `timeout_err`.

## Interface
- `TIMEOUT_CYC`, default 48: cycles from `do_it` before a transaction is abandoned; range 40..63.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: request; sampled only in IDLE.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 8: RTC register address.
- `req_wdata` in 8: write data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 8: captured read data; valid from `ack` until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse on abandon.
- `do_it` out 1: start pulse to the bus-cycle FSM.
- `w_r` out 1: direction to the bus-cycle FSM, held for the whole transaction.
- `send_add` in 1: address-phase flag from the bus-cycle FSM.
- `send_data` in 1: write-data-phase flag from the bus-cycle FSM.
- `read_data` in 1: read-capture flag from the bus-cycle FSM.
- `ad_out` out 8: bus drive value.
- `ad_oe` out 1: tri-state enable; the top level builds the inout.
- `ad_in` in 8: bus sampled value.

## Operation
- State machine: IDLE -> START -> WAIT_ADD -> WAIT_DATA -> DONE -> IDLE.
- IDLE, `req`=1: latch `req_wr`, `req_addr` and `req_wdata` into internal registers; go to START. Inputs are never resampled mid-transaction.
- START: `do_it`=1 for exactly one cycle; timeout counter cleared; go to WAIT_ADD.
- WAIT_ADD:
  - `ad_out`=addr_reg and `ad_oe` = `send_add` (combinational).
  - Fall of `send_add` (registered previous value 1, current value 0) -> WAIT_DATA.
- WAIT_DATA, write:
  - `ad_out`=wdata_reg and `ad_oe` = `send_data`.
  - Fall of `send_data` -> DONE.
- WAIT_DATA, read:
  - `ad_oe`=0.
  - `rdata` <= `ad_in` at the end of the first cycle with `read_data`=1 (rise detect); captured once only.
  - Fall of `read_data` -> DONE.
- DONE: `ack`=1 for one cycle -> IDLE.
- Flags not belonging to the current state are ignored, e.g. `send_data` in WAIT_ADD or `read_data` during a write.
- `w_r` equals the latched direction in all non-IDLE states and 0 in IDLE.
- `ad_oe`=0 in IDLE, START and DONE, and at all times during a read's data phase. The block never drives the bus while the RTC may drive it.
- Timeout:
  - 6-bit counter increments every cycle from START through WAIT_DATA.
  - Counter == `TIMEOUT_CYC`-1 with no completion -> `timeout_err`=1 for one cycle, state IDLE, no `ack`, `rdata` unchanged.
  - Completion detected in the same cycle as the timeout wins: DONE is entered and `timeout_err` stays 0.
- `req` during `busy` is ignored, not queued. A request held high during DONE is accepted in the following IDLE cycle.

## Timing
- Reset values: state IDLE; `ack`, `busy`, `timeout_err`, `do_it`, `w_r` and `ad_oe` all 0; `ad_out`=0; `rdata`=0; internal registers 0.
- Reset mid-transaction: outputs return to these values asynchronously, the bus is released at once, and no `ack` is issued.
- `req` sampled in IDLE at cycle t -> `busy`=1 and `do_it`=1 at cycle t+1.
- `ack` is asserted in the cycle after the first cycle in which the final flag is seen low following high.
- Minimum spacing between accepted requests: `ack` cycle + 1 (back-to-back through IDLE).
- Reference bus-cycle FSM profile, cycles counted from the `do_it` cycle = 0:
  - `send_add` high in cycles 3..12.
  - Write: `send_data` high in cycles 24..34.
  - Read: `read_data` high in cycles 32..34.
  - Resulting `ack` in cycle 36; `busy` high in cycles 0..36.

## Test plan
- Write: `req`, `req_wr`=1, addr 0x21, data 0x5A, with the reference bus profile -> `ad_oe`=1 with `ad_out`=0x21 in cycles 3..12; `ad_oe`=1 with `ad_out`=0x5A in cycles 24..34; `ack` in cycle 36; `w_r`=1 in cycles 0..36.
- Read: addr 0x23; `ad_in`=0x47 in cycle 32, then 0x00 -> `rdata`=0x47 at `ack` in cycle 36; `ad_oe` never 1 in cycles 13..36.
- Timeout: model never raises `send_data` -> `timeout_err` pulse in cycle 47; no `ack`; IDLE next cycle; new `req` accepted normally.
- Busy rejection: second `req` (addr 0x99) asserted in cycles 5..10 -> ignored, first transaction unchanged; `req` held high through DONE -> new `do_it` 2 cycles after `ack`.
- Reset: `reset` low in cycle 28 of a write -> `ad_oe`, `do_it`, `busy` and `w_r` are 0 immediately; after release, no spurious `ack` or `timeout_err`.
- Stray flags: `read_data` pulsed during a write and `send_data` pulsed in WAIT_ADD -> no state change and no `rdata` update.
